// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence front end and the downstream sequence FSMs.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } seq_state_e;

  // Number of bits needed to hold any value in 0..max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) <= max_val) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// WIDTH-bit load/shift register; out_bit is the bit currently at the output end.
module seq_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             out_bit
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      always_comb begin
        sr_d = sr_q;
        if (load)       sr_d = din;
        else if (shift) sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end
      assign out_bit = sr_q[WIDTH-1];
    end else begin : g_lsb
      always_comb begin
        sr_d = sr_q;
        if (load)       sr_d = din;
        else if (shift) sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
      assign out_bit = sr_q[0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: valid/ready word load, one bit per clock on seq,
// framing strobes, optional idle gap and a wrapping count of completed frames.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   GAP       = 1,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             seq,
  output logic             seq_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic [7:0]       frame_cnt
);

  localparam int BW = cnt_width(WIDTH - 1);
  localparam int GW = cnt_width(GAP);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  seq_state_e    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          seq_valid_q, seq_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_done_q, frame_done_d;
  logic          sr_load, sr_shift, sr_bit;

  seq_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .load   (sr_load),
    .shift  (sr_shift),
    .din    (din),
    .out_bit(sr_bit)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    seq_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    sr_load       = 1'b0;
    sr_shift      = 1'b0;
    load_ready    = 1'b0;

    case (state_q)
      ST_IDLE: load_ready = 1'b1;
      ST_SHIFT: begin
        if (bit_cnt_q != '0) begin
          sr_shift     = 1'b1;
          bit_cnt_d    = bit_cnt_q - BW'(1);
          seq_valid_d  = 1'b1;
          frame_done_d = (bit_cnt_q == BW'(1));
        end else begin
          // Last-bit cycle: the frame is complete at this edge.
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d    = ST_IDLE;
            load_ready = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // A load overrides the shift decisions above, giving a bubble-free start when GAP is 0.
    if (load_ready && load_valid) begin
      sr_load       = 1'b1;
      sr_shift      = 1'b0;
      bit_cnt_d     = BIT_LAST;
      seq_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      frame_done_d  = 1'b0;
      state_d       = ST_SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      seq_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      seq_valid_q   <= seq_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Only flops feed seq: the shifter head bit, forced to IDLE_BIT outside a frame.
  assign seq         = seq_valid_q ? sr_bit : IDLE_BIT;
  assign seq_valid   = seq_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: three parameterisations checked every cycle against a
// frame-level model, plus directed vectors with hand-computed expectations.
module tb_seq_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]   lv;
  logic [2:0]   ready_o, seq_o, sv_o, fs_o, fd_o;
  logic [W-1:0] din [3];
  logic [7:0]   fcnt [3];

  int n_vec = 0;
  int n_err = 0;

  // Instance 0: GAP=1 MSB-first, 1: GAP=1 LSB-first, 2: GAP=0 MSB-first.
  function automatic int gap_of(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic int msb_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    seq_serializer #(
      .WIDTH    (W),
      .GAP      (gap_of(gi)),
      .MSB_FIRST(msb_of(gi)),
      .IDLE_BIT (1'b0)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din[gi]),
      .load_valid (lv[gi]),
      .load_ready (ready_o[gi]),
      .seq        (seq_o[gi]),
      .seq_valid  (sv_o[gi]),
      .frame_start(fs_o[gi]),
      .frame_done (fd_o[gi]),
      .frame_cnt  (fcnt[gi])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: bits left in the current frame, idle gap cycles left, frames done.
  int           m_left [3] = '{0, 0, 0};
  int           m_gap  [3] = '{0, 0, 0};
  logic [W-1:0] m_word [3] = '{0, 0, 0};
  logic [7:0]   m_cnt  [3] = '{0, 0, 0};
  bit           m_start[3] = '{0, 0, 0};

  function automatic bit m_ready(input int k);
    return (m_left[k] == 0 && m_gap[k] == 0) || (gap_of(k) == 0 && m_left[k] == 1);
  endfunction

  initial begin
    bit hs;
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          m_left[k] = 0; m_gap[k] = 0; m_cnt[k] = 0; m_start[k] = 0; m_word[k] = 0;
        end else begin
          hs = lv[k] && m_ready(k);
          m_start[k] = 0;
          if (m_left[k] > 0) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_cnt[k]++;
              m_gap[k] = gap_of(k);
            end
          end else if (m_gap[k] > 0) begin
            m_gap[k]--;
          end
          if (hs) begin
            m_word[k]  = din[k];
            m_left[k]  = W;
            m_start[k] = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all three instances against the model.
  initial begin
    bit eb;
    int pos;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 3; k++) begin
          eb = 1'b0;
          if (m_left[k] > 0) begin
            pos = W - m_left[k];
            eb  = (msb_of(k) != 0) ? m_word[k][W-1-pos] : m_word[k][pos];
          end
          chk($sformatf("seq[%0d]", k),         32'(seq_o[k]),   32'(eb));
          chk($sformatf("seq_valid[%0d]", k),   32'(sv_o[k]),    32'(m_left[k] > 0));
          chk($sformatf("frame_start[%0d]", k), 32'(fs_o[k]),    32'(m_start[k]));
          chk($sformatf("frame_done[%0d]", k),  32'(fd_o[k]),    32'(m_left[k] == 1));
          chk($sformatf("frame_cnt[%0d]", k),   32'(fcnt[k]),    32'(m_cnt[k]));
          chk($sformatf("load_ready[%0d]", k),  32'(ready_o[k]), 32'(m_ready(k)));
        end
      end
    end
  end

  initial begin
    logic [7:0]  cap, capb;
    logic [15:0] cap16;
    int          nv, nfs;

    lv = '0;
    din = '{default: '0};
    repeat (2) @(negedge clk);
    chk("rst_seq",        32'(seq_o[0]),   32'd0);
    chk("rst_seq_valid",  32'(sv_o[0]),    32'd0);
    chk("rst_frame_cnt",  32'(fcnt[0]),    32'd0);
    chk("rst_load_ready", 32'(ready_o[0]), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // MSB-first and LSB-first frames of 8'hB2.
    din[0] = 8'hB2; din[1] = 8'hB2; lv[0] = 1'b1; lv[1] = 1'b1;
    @(negedge clk);
    lv[0] = 1'b0; lv[1] = 1'b0; din[0] = 8'h00; din[1] = 8'h00;
    cap = '0; capb = '0;
    for (int i = 0; i < 8; i++) begin
      cap  = {cap[6:0], seq_o[0]};
      capb = {capb[6:0], seq_o[1]};
      if (i == 0) chk("msb_frame_start_c1", 32'(fs_o[0]), 32'd1);
      if (i == 7) chk("msb_frame_done_c8",  32'(fd_o[0]), 32'd1);
      @(negedge clk);
    end
    chk("msb_bits", 32'(cap),  32'hB2);
    chk("lsb_bits", 32'(capb), 32'h4D);
    chk("gap_c9_valid", 32'(sv_o[0]),    32'd0);
    chk("gap_c9_ready", 32'(ready_o[0]), 32'd0);
    chk("gap_c9_cnt",   32'(fcnt[0]),    32'd1);
    @(negedge clk);
    chk("ready_c10", 32'(ready_o[0]), 32'd1);

    // Back-to-back frames with GAP=0.
    din[2] = 8'hFF; lv[2] = 1'b1;
    @(negedge clk);
    din[2] = 8'h00;
    nv = 0; cap16 = '0;
    for (int i = 0; i < 16; i++) begin
      nv += int'(sv_o[2]);
      cap16 = {cap16[14:0], seq_o[2]};
      if (i == 0 || i == 8) chk("b2b_frame_start", 32'(fs_o[2]), 32'd1);
      if (i == 8) lv[2] = 1'b0;
      @(negedge clk);
    end
    chk("b2b_valid_run", 32'(nv),     32'd16);
    chk("b2b_bits",      32'(cap16),  32'hFF00);
    chk("b2b_cnt",       32'(fcnt[2]), 32'd2);
    chk("b2b_idle",      32'(sv_o[2]), 32'd0);

    // Busy: load_valid pulsed and din changed while shifting.
    din[0] = 8'hA5; lv[0] = 1'b1;
    @(negedge clk);
    lv[0] = 1'b0; cap = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin din[0] = 8'h3C; lv[0] = 1'b1; end
      if (i == 4) lv[0] = 1'b0;
      if (i == 5) lv[0] = 1'b1;
      cap = {cap[6:0], seq_o[0]};
      @(negedge clk);
    end
    chk("busy_bits_unchanged", 32'(cap), 32'hA5);
    for (int i = 0; i < 20 && !fs_o[0]; i++) @(negedge clk);
    chk("busy_next_start", 32'(fs_o[0]), 32'd1);
    lv[0] = 1'b0; cap = '0;
    for (int i = 0; i < 8; i++) begin
      cap = {cap[6:0], seq_o[0]};
      @(negedge clk);
    end
    chk("busy_second_bits", 32'(cap), 32'h3C);
    chk("busy_cnt", 32'(fcnt[0]), 32'd3);

    // Reset in cycle 4 of a frame.
    @(negedge clk);
    din[0] = 8'h5A; lv[0] = 1'b1;
    @(negedge clk);
    lv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_seq",         32'(seq_o[0]), 32'd0);
    chk("rstmid_seq_valid",   32'(sv_o[0]),  32'd0);
    chk("rstmid_frame_cnt",   32'(fcnt[0]),  32'd0);
    chk("rstmid_frame_start", 32'(fs_o[0]),  32'd0);
    chk("rstmid_frame_done",  32'(fd_o[0]),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_ready", 32'(ready_o[0]), 32'd1);
    din[0] = 8'h96; lv[0] = 1'b1;
    @(negedge clk);
    lv[0] = 1'b0; cap = '0;
    for (int i = 0; i < 8; i++) begin
      cap = {cap[6:0], seq_o[0]};
      @(negedge clk);
    end
    chk("rstmid_next_bits", 32'(cap),     32'h96);
    chk("rstmid_next_cnt",  32'(fcnt[0]), 32'd1);

    // Frame counter wrap on the GAP=0 instance.
    din[2] = 8'($urandom); lv[2] = 1'b1; nfs = 0;
    for (int i = 0; i < 4000 && nfs < 256; i++) begin
      @(negedge clk);
      if (fs_o[2]) begin
        nfs++;
        din[2] = 8'($urandom);
      end
    end
    lv[2] = 1'b0;
    chk("wrap_frames", 32'(nfs), 32'd256);
    repeat (9) @(negedge clk);
    chk("wrap_cnt_0", 32'(fcnt[2]), 32'd0);
    din[2] = 8'h11; lv[2] = 1'b1;
    @(negedge clk);
    lv[2] = 1'b0;
    repeat (9) @(negedge clk);
    chk("wrap_cnt_1", 32'(fcnt[2]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
